// File: rtl/l2_bus_sequencer.sv
// Sequences one MESI-stage request onto the shared bus: an optional victim evict and writeback,
// then the main op. The snoop result goes back to the MESI stage; the L1 gets an EVICTLINE message.
module l2_bus_sequencer #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned SNOOP_TIMEOUT = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_busop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_evict,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_vaddr,
    output logic              bus_valid,
    output logic [2:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_in,
    output logic              rsp_valid,
    output logic [1:0]        rsp_snoop,
    output logic              l1_msg_valid,
    output logic [2:0]        l1_msg,
    output logic [ADDR_W-1:0] l1_msg_addr,
    output logic [CNT_W-1:0]  cnt_busops,
    output logic [CNT_W-1:0]  cnt_timeouts
);

    localparam int unsigned TMR_W    = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [2:0]  OpNone   = 3'd0;
    localparam logic [2:0]  OpRead   = 3'd1;
    localparam logic [2:0]  OpWrite  = 3'd2;
    localparam logic [2:0]  OpRwim   = 3'd4;
    localparam logic [2:0]  MsgEvict = 3'd4;

    typedef enum logic [2:0] {
        StIdle, StEvict, StWbIssue, StOpIssue, StSnoopWait, StResp
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d, req_op;
    logic [ADDR_W-1:0]  addr_q, addr_d, vaddr_q, vaddr_d;
    logic               wb_q, wb_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         snoop_res;
    logic               req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [1:0]         rsp_snoop_q, rsp_snoop_d;
    logic               bus_valid_q, bus_valid_d, l1_msg_valid_q, l1_msg_valid_d;
    logic [2:0]         bus_op_q, bus_op_d, l1_msg_q, l1_msg_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d, l1_msg_addr_q, l1_msg_addr_d;
    logic [CNT_W-1:0]   cnt_busops_q, cnt_busops_d, cnt_timeouts_q, cnt_timeouts_d;

    // Reserved op codes collapse to NONE at capture.
    assign req_op = (req_busop > 3'd4) ? OpNone : req_busop;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        vaddr_d        = vaddr_q;
        wb_d           = wb_q;
        timer_d        = timer_q;
        snoop_res      = 2'd0;
        cnt_busops_d   = cnt_busops_q;
        cnt_timeouts_d = cnt_timeouts_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    vaddr_d = req_vaddr;
                    wb_d    = req_evict & req_wb;
                    if (req_evict)            state_d = StEvict;
                    else if (req_op != OpNone) state_d = StOpIssue;
                    else                      state_d = StResp;
                end
            end
            StEvict: begin
                if (wb_q)                 state_d = StWbIssue;
                else if (op_q != OpNone)  state_d = StOpIssue;
                else                      state_d = StResp;
            end
            StWbIssue: begin
                if (bus_ack) state_d = (op_q != OpNone) ? StOpIssue : StResp;
            end
            StOpIssue: begin
                if (bus_ack) begin
                    if (op_q == OpRead || op_q == OpRwim) begin
                        state_d = StSnoopWait;
                        timer_d = '0;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StSnoopWait: begin
                timer_d = timer_q + TMR_W'(1);
                // A snoop arriving in the last allowed cycle beats the timeout.
                if (snoop_valid) begin
                    snoop_res = (snoop_in == 2'd3) ? 2'd0 : snoop_in;
                    state_d   = StResp;
                end else if (timer_q == TMR_W'(SNOOP_TIMEOUT - 1)) begin
                    state_d = StResp;
                    if (cnt_timeouts_q != {CNT_W{1'b1}}) cnt_timeouts_d = cnt_timeouts_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (bus_ack && (state_q == StWbIssue || state_q == StOpIssue) &&
            cnt_busops_q != {CNT_W{1'b1}}) begin
            cnt_busops_d = cnt_busops_q + 1'b1;
        end

        // Outputs are registered from the next state so they line up with state_q.
        req_ready_d    = (state_d == StIdle);
        rsp_valid_d    = (state_d == StResp);
        rsp_snoop_d    = (state_d == StResp) ? snoop_res : rsp_snoop_q;
        bus_valid_d    = (state_d == StWbIssue) || (state_d == StOpIssue);
        bus_op_d       = (state_d == StWbIssue) ? OpWrite :
                         (state_d == StOpIssue) ? op_d : OpNone;
        bus_addr_d     = (state_d == StWbIssue) ? vaddr_d :
                         (state_d == StOpIssue) ? addr_d : '0;
        l1_msg_valid_d = (state_d == StEvict);
        l1_msg_d       = (state_d == StEvict) ? MsgEvict : 3'd0;
        l1_msg_addr_d  = (state_d == StEvict) ? vaddr_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            op_q           <= OpNone;
            addr_q         <= '0;
            vaddr_q        <= '0;
            wb_q           <= 1'b0;
            timer_q        <= '0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_snoop_q    <= 2'd0;
            bus_valid_q    <= 1'b0;
            bus_op_q       <= 3'd0;
            bus_addr_q     <= '0;
            l1_msg_valid_q <= 1'b0;
            l1_msg_q       <= 3'd0;
            l1_msg_addr_q  <= '0;
            cnt_busops_q   <= '0;
            cnt_timeouts_q <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            vaddr_q        <= vaddr_d;
            wb_q           <= wb_d;
            timer_q        <= timer_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_snoop_q    <= rsp_snoop_d;
            bus_valid_q    <= bus_valid_d;
            bus_op_q       <= bus_op_d;
            bus_addr_q     <= bus_addr_d;
            l1_msg_valid_q <= l1_msg_valid_d;
            l1_msg_q       <= l1_msg_d;
            l1_msg_addr_q  <= l1_msg_addr_d;
            cnt_busops_q   <= cnt_busops_d;
            cnt_timeouts_q <= cnt_timeouts_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_snoop    = rsp_snoop_q;
    assign bus_valid    = bus_valid_q;
    assign bus_op       = bus_op_q;
    assign bus_addr     = bus_addr_q;
    assign l1_msg_valid = l1_msg_valid_q;
    assign l1_msg       = l1_msg_q;
    assign l1_msg_addr  = l1_msg_addr_q;
    assign cnt_busops   = cnt_busops_q;
    assign cnt_timeouts = cnt_timeouts_q;

endmodule

// File: tb/tb_l2_bus_sequencer.sv
// Bench for l2_bus_sequencer: directed table, randomized requests against a transaction-level
// model, and a mid-operation reset sequence.
module tb_l2_bus_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int          TMO    = 8;
    localparam int unsigned CNT_W  = 16;

    logic              clk, rst_n;
    logic              req_valid, req_ready, req_evict, req_wb;
    logic [2:0]        req_busop;
    logic [ADDR_W-1:0] req_addr, req_vaddr;
    logic              bus_valid, bus_ack, snoop_valid, rsp_valid, l1_msg_valid;
    logic [2:0]        bus_op, l1_msg;
    logic [ADDR_W-1:0] bus_addr, l1_msg_addr;
    logic [1:0]        snoop_in, rsp_snoop;
    logic [CNT_W-1:0]  cnt_busops, cnt_timeouts;

    l2_bus_sequencer #(.ADDR_W(ADDR_W), .SNOOP_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_busop(req_busop),
        .req_addr(req_addr), .req_evict(req_evict), .req_wb(req_wb), .req_vaddr(req_vaddr),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ack(bus_ack),
        .snoop_valid(snoop_valid), .snoop_in(snoop_in),
        .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop),
        .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_msg_addr(l1_msg_addr),
        .cnt_busops(cnt_busops), .cnt_timeouts(cnt_timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       busop;
        logic [31:0]      addr;
        logic             evict;
        logic             wb;
        logic [31:0]      vaddr;
        int               ack0;       // cycles bus_valid is held before ack, first bus op
        int               ack1;       // same, second bus op
        int               snoop_dly;  // wait cycles before snoop_valid; >= TMO means never
        logic [1:0]       snoop_val;
        int               e_lat;      // edges from accept edge to rsp sampling edge, inclusive
        logic [1:0]       e_snoop;
        int               e_nbus;
        logic [1:0][2:0]  e_op;
        logic [1:0][31:0] e_addr;
        int               e_nl1;
        int               e_tmo;
    } vec_t;

    typedef struct {
        logic             got_rsp;
        int               lat;
        logic [1:0]       snoop;
        int               nbus;
        logic [1:0][2:0]  op;
        logic [1:0][31:0] addr;
        logic [1:0][7:0]  held;
        int               nl1;
        logic [31:0]      l1addr;
        int               l1_bad;
        int               unstable;
        int               busy_ready;
        logic             rsp_after;
        logic [1:0]       snoop_after;
    } obs_t;

    int checks = 0;
    int failures = 0;
    int cur_id = -1;
    int exp_busops = 0;
    int exp_tmo = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", cur_id, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic ev,
                                input logic wb, input logic [31:0] va, input int a0, input int a1,
                                input int sd, input logic [1:0] sv, input int lat,
                                input logic [1:0] esn, input int nb, input logic [2:0] o0,
                                input logic [31:0] ad0, input logic [2:0] o1,
                                input logic [31:0] ad1, input int nl1, input int tmo);
        vec_t r;
        r.busop = op;  r.addr = a;  r.evict = ev;  r.wb = wb;  r.vaddr = va;
        r.ack0 = a0;  r.ack1 = a1;  r.snoop_dly = sd;  r.snoop_val = sv;
        r.e_lat = lat;  r.e_snoop = esn;  r.e_nbus = nb;
        r.e_op[0] = o0;  r.e_addr[0] = ad0;  r.e_op[1] = o1;  r.e_addr[1] = ad1;
        r.e_nl1 = nl1;  r.e_tmo = tmo;
        return r;
    endfunction

    // Transaction-level reference: list the bus ops a request implies and add up its cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   mop;
        r = v;
        r.e_op = '0;  r.e_addr = '0;  r.e_nbus = 0;  r.e_tmo = 0;  r.e_snoop = 2'd0;
        mop = (v.busop >= 3'd1 && v.busop <= 3'd4) ? int'(v.busop) : 0;
        r.e_nl1 = v.evict ? 1 : 0;
        r.e_lat = 2 + r.e_nl1;
        if (v.evict && v.wb) begin
            r.e_op[0] = 3'd2;  r.e_addr[0] = v.vaddr;  r.e_nbus = 1;
            r.e_lat += v.ack0 + 1;
        end
        if (mop != 0) begin
            r.e_op[r.e_nbus] = 3'(mop);
            r.e_addr[r.e_nbus] = v.addr;
            r.e_lat += ((r.e_nbus == 0) ? v.ack0 : v.ack1) + 1;
            r.e_nbus++;
        end
        if (mop == 1 || mop == 4) begin
            if (v.snoop_dly < TMO) begin
                r.e_lat += v.snoop_dly + 1;
                r.e_snoop = (v.snoop_val == 2'd3) ? 2'd0 : v.snoop_val;
            end else begin
                r.e_lat += TMO;
                r.e_tmo = 1;
            end
        end
        return r;
    endfunction

    // Issues one request and plays the bus and snooping caches; noise is injected wherever
    // the sequencer must ignore bus_ack or snoop_valid.
    task automatic run_txn(input vec_t v, output obs_t o);
        int         held, win, dly, lat;
        logic [2:0] cop;
        logic [31:0] cad;
        o = '{default: 0};
        held = 0;  win = -1;  cop = 3'd0;  cad = 32'd0;
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;  req_busop = v.busop;  req_addr = v.addr;
        req_evict = v.evict;  req_wb = v.wb;  req_vaddr = v.vaddr;
        @(posedge clk); #1;
        req_valid = 1'b0;  req_busop = 3'($urandom);  req_addr = $urandom;
        req_evict = 1'($urandom);  req_wb = 1'($urandom);  req_vaddr = $urandom;
        for (lat = 1; lat < 200; lat++) begin
            bus_ack = 1'b0;  snoop_valid = 1'b0;  snoop_in = 2'($urandom);
            if (rsp_valid) begin
                o.got_rsp = 1'b1;  o.lat = lat + 1;  o.snoop = rsp_snoop;
                break;
            end
            if (req_ready) o.busy_ready++;
            if (l1_msg_valid) begin
                o.nl1++;
                o.l1addr = l1_msg_addr;
                if (l1_msg != 3'd4) o.l1_bad++;
            end
            if (bus_valid) begin
                if (held == 0) begin
                    cop = bus_op;  cad = bus_addr;
                end else if (bus_op !== cop || bus_addr !== cad) begin
                    o.unstable++;
                end
                snoop_valid = 1'($urandom);
                dly = (o.nbus == 0) ? v.ack0 : v.ack1;
                if (held == dly) begin
                    bus_ack = 1'b1;
                    if (o.nbus < 2) begin
                        o.op[o.nbus] = cop;  o.addr[o.nbus] = cad;
                        o.held[o.nbus] = 8'(held + 1);
                    end
                    o.nbus++;
                    held = 0;
                    if (cop == 3'd1 || cop == 3'd4) win = 0;
                end else begin
                    held++;
                end
            end else begin
                bus_ack = 1'($urandom);
                if (win >= 0) begin
                    if (win == v.snoop_dly) begin
                        snoop_valid = 1'b1;  snoop_in = v.snoop_val;
                    end
                    win++;
                end else begin
                    snoop_valid = 1'($urandom);
                end
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;  snoop_valid = 1'b0;
        @(posedge clk); #1;
        o.rsp_after = rsp_valid;
        o.snoop_after = rsp_snoop;
    endtask

    task automatic compare(input vec_t e, input obs_t o);
        check("rsp_seen", 64'(o.got_rsp), 64'd1);
        check("latency", 64'(o.lat), 64'(e.e_lat));
        check("rsp_snoop", 64'(o.snoop), 64'(e.e_snoop));
        check("rsp_pulse", 64'(o.rsp_after), 64'd0);
        check("snoop_hold", 64'(o.snoop_after), 64'(e.e_snoop));
        check("ready_busy", 64'(o.busy_ready), 64'd0);
        check("n_busops", 64'(o.nbus), 64'(e.e_nbus));
        check("n_l1msg", 64'(o.nl1), 64'(e.e_nl1));
        check("bus_stable", 64'(o.unstable), 64'd0);
        if (e.e_nl1 != 0) begin
            check("l1_addr", 64'(o.l1addr), 64'(e.vaddr));
            check("l1_code", 64'(o.l1_bad), 64'd0);
        end
        for (int k = 0; k < 2; k++) begin
            if (k < e.e_nbus) begin
                check("bus_op", 64'(o.op[k]), 64'(e.e_op[k]));
                check("bus_addr", 64'(o.addr[k]), 64'(e.e_addr[k]));
                check("bus_held", 64'(o.held[k]), 64'(((k == 0) ? e.ack0 : e.ack1) + 1));
            end
        end
        exp_busops += e.e_nbus;
        exp_tmo += e.e_tmo;
        check("cnt_busops", 64'(cnt_busops), 64'(exp_busops));
        check("cnt_timeouts", 64'(cnt_timeouts), 64'(exp_tmo));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_bus_valid"}, 64'(bus_valid), 64'd0);
        check({tag, "_bus_op"}, 64'(bus_op), 64'd0);
        check({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_snoop"}, 64'(rsp_snoop), 64'd0);
        check({tag, "_l1_valid"}, 64'(l1_msg_valid), 64'd0);
        check({tag, "_l1_msg"}, 64'(l1_msg), 64'd0);
        check({tag, "_cnt_busops"}, 64'(cnt_busops), 64'd0);
        check({tag, "_cnt_tmo"}, 64'(cnt_timeouts), 64'd0);
    endtask

    vec_t tbl[12];
    vec_t v;
    obs_t o;
    int   stray;

    initial begin
        rst_n = 1'b0;  req_valid = 1'b0;  req_busop = 3'd0;  req_addr = '0;  req_evict = 1'b0;
        req_wb = 1'b0;  req_vaddr = '0;  bus_ack = 1'b0;  snoop_valid = 1'b0;  snoop_in = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = mk(3'd1, 32'h1000, 0, 0, 32'h0,    0, 0, 0,  2'd1, 4,  2'd1, 1,
                     3'd1, 32'h1000, 3'd0, 32'h0,    0, 0);
        tbl[1]  = mk(3'd4, 32'h4000, 0, 0, 32'h0,    0, 0, 20, 2'd1, 11, 2'd0, 1,
                     3'd4, 32'h4000, 3'd0, 32'h0,    0, 1);
        tbl[2]  = mk(3'd1, 32'h2000, 1, 1, 32'h3000, 0, 0, 0,  2'd2, 6,  2'd2, 2,
                     3'd2, 32'h3000, 3'd1, 32'h2000, 1, 0);
        tbl[3]  = mk(3'd2, 32'h5000, 0, 0, 32'h0,    5, 0, 0,  2'd1, 8,  2'd0, 1,
                     3'd2, 32'h5000, 3'd0, 32'h0,    0, 0);
        tbl[4]  = mk(3'd1, 32'h6000, 0, 0, 32'h0,    0, 0, 2,  2'd3, 6,  2'd0, 1,
                     3'd1, 32'h6000, 3'd0, 32'h0,    0, 0);
        tbl[5]  = mk(3'd0, 32'h1234, 0, 0, 32'h0,    0, 0, 0,  2'd1, 2,  2'd0, 0,
                     3'd0, 32'h0,    3'd0, 32'h0,    0, 0);
        tbl[6]  = mk(3'd0, 32'h0,    1, 0, 32'h7000, 0, 0, 0,  2'd1, 3,  2'd0, 0,
                     3'd0, 32'h0,    3'd0, 32'h0,    1, 0);
        tbl[7]  = mk(3'd6, 32'h5555, 0, 1, 32'h6666, 0, 0, 0,  2'd1, 2,  2'd0, 0,
                     3'd0, 32'h0,    3'd0, 32'h0,    0, 0);
        tbl[8]  = mk(3'd4, 32'hA000, 0, 0, 32'h0,    1, 0, 7,  2'd2, 12, 2'd2, 1,
                     3'd4, 32'hA000, 3'd0, 32'h0,    0, 0);
        tbl[9]  = mk(3'd3, 32'h8000, 1, 1, 32'h9000, 2, 1, 0,  2'd1, 8,  2'd0, 2,
                     3'd2, 32'h9000, 3'd3, 32'h8000, 1, 0);
        tbl[10] = mk(3'd1, 32'hB000, 1, 0, 32'hC000, 3, 0, 0,  2'd1, 8,  2'd1, 1,
                     3'd1, 32'hB000, 3'd0, 32'h0,    1, 0);
        tbl[11] = mk(3'd7, 32'hD000, 1, 1, 32'hE000, 0, 0, 0,  2'd1, 4,  2'd0, 1,
                     3'd2, 32'hE000, 3'd0, 32'h0,    1, 0);

        for (int i = 0; i < 12; i++) begin
            cur_id = i;
            run_txn(tbl[i], o);
            compare(tbl[i], o);
        end

        for (int i = 0; i < 60; i++) begin
            cur_id = 100 + i;
            v = '{default: 0};
            v.busop = 3'($urandom_range(0, 7));
            v.addr = $urandom;
            v.evict = 1'($urandom);
            v.wb = 1'($urandom);
            v.vaddr = $urandom;
            v.ack0 = int'($urandom_range(0, 4));
            v.ack1 = int'($urandom_range(0, 4));
            v.snoop_dly = int'($urandom_range(0, 11));
            v.snoop_val = 2'($urandom);
            v = model(v);
            run_txn(v, o);
            compare(v, o);
        end

        // Reset while waiting for a snoop: everything clears at once, nothing trails afterwards.
        cur_id = 200;
        req_valid = 1'b1;  req_busop = 3'd1;  req_addr = 32'h1000;  req_evict = 1'b0;
        req_wb = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        exp_busops = 0;
        exp_tmo = 0;
        @(negedge clk) rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || bus_valid || l1_msg_valid || !req_ready) stray++;
        end
        check("post_reset_quiet", 64'(stray), 64'd0);

        cur_id = 201;
        v = model(mk(3'd4, 32'hF000, 1, 1, 32'hF100, 1, 2, 3, 2'd2, 0, 2'd0, 0,
                     3'd0, 32'h0, 3'd0, 32'h0, 0, 0));
        run_txn(v, o);
        compare(v, o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
